// File: rtl/pingpong_wr_ctrl.sv
// pingpong_wr_ctrl: two-source word arbiter and write sequencer for a ping-pong frame buffer
// Define PPCTRL_STALL_CNT_EN to count cycles spent blocked on the reader in stall_cycles.
module pingpong_wr_ctrl #(
    parameter int WORDS_PER_FRAME = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] src0_data,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [31:0] src1_data,
    input  logic        src1_valid,
    output logic        src1_ready,
    input  logic        rd_done,
    output logic [31:0] buf_wr_data,
    output logic [6:0]  buf_wr_addr,
    output logic        buf_wr_en,
    output logic        buf_switch,
    output logic        frame_ready,
    output logic        wait_rd,
    output logic [15:0] stall_cycles
);
    typedef enum logic [1:0] {FILL, DRAIN, WAIT_RD} state_t;
    state_t r_state, w_next;
    logic [6:0] r_wcnt;
    logic r_last_served, r_reader_free;
    logic w_fill, w_gnt0, w_gnt1, w_acc0, w_acc1, w_acc, w_last, w_switch;
    assign w_fill = r_state == FILL;
    assign w_gnt0 = src0_valid & (~src1_valid | r_last_served);
    assign w_gnt1 = src1_valid & (~src0_valid | ~r_last_served);
    assign src0_ready = w_fill & w_gnt0;
    assign src1_ready = w_fill & w_gnt1;
    assign w_acc0 = src0_valid & src0_ready;
    assign w_acc1 = src1_valid & src1_ready;
    assign w_acc = w_acc0 | w_acc1;
    assign w_last = w_acc & (r_wcnt == 7'(WORDS_PER_FRAME - 1));
    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = w_fill ? (w_last ? DRAIN : FILL)
               : w_switch ? FILL
               : (r_state == DRAIN || r_state == WAIT_RD) ? WAIT_RD
               : FILL;
    end
    always_comb begin
        w_switch = (r_state == DRAIN && (r_reader_free || rd_done)) || (r_state == WAIT_RD && rd_done);
        wait_rd  = r_state == WAIT_RD;
    end
    assign buf_switch  = w_switch;
    assign frame_ready = w_switch;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt        <= '0;
            r_last_served <= 1'b1;
            r_reader_free <= 1'b1;
            buf_wr_en     <= 1'b0;
            buf_wr_addr   <= '0;
            buf_wr_data   <= '0;
        end else begin
            buf_wr_en     <= w_acc;
            // a swap consumes any coincident rd_done
            r_reader_free <= w_switch ? 1'b0 : (rd_done ? 1'b1 : r_reader_free);
            if (w_acc) begin
                buf_wr_data   <= w_acc1 ? src1_data : src0_data;
                buf_wr_addr   <= r_wcnt;
                r_wcnt        <= w_last ? 7'd0 : r_wcnt + 7'd1;
                r_last_served <= w_acc1;
            end
        end
    end
`ifdef PPCTRL_STALL_CNT_EN
    logic [15:0] r_stall;
    always_ff @(posedge clk) begin
        if (rst) r_stall <= '0;
        else if (wait_rd && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end
    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// tb_pingpong_wr_ctrl: directed bench for pingpong_wr_ctrl (128-word and 2-word frames)
module tb_pingpong_wr_ctrl;
    logic clk = 0, rst = 1, b_rst = 1;
    logic [31:0] s0_data = 0, s1_data = 0, b0_data = 0, b1_data = 0;
    logic s0_valid = 0, s1_valid = 0, rd_done = 0, b0_valid = 0, b1_valid = 0, b_rd_done = 0;
    logic s0_ready, s1_ready, wr_en, sw, fr, wt, b0_ready, b1_ready, b_wr_en, b_sw, b_fr, b_wt;
    logic [31:0] wr_data, b_wr_data;
    logic [6:0] wr_addr, b_wr_addr;
    logic [15:0] stall, b_stall;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    pingpong_wr_ctrl u_dut (
        .clk(clk), .rst(rst),
        .src0_data(s0_data), .src0_valid(s0_valid), .src0_ready(s0_ready),
        .src1_data(s1_data), .src1_valid(s1_valid), .src1_ready(s1_ready),
        .rd_done(rd_done), .buf_wr_data(wr_data), .buf_wr_addr(wr_addr), .buf_wr_en(wr_en),
        .buf_switch(sw), .frame_ready(fr), .wait_rd(wt), .stall_cycles(stall)
    );
    pingpong_wr_ctrl #(.WORDS_PER_FRAME(2)) u_dut2 (
        .clk(clk), .rst(b_rst),
        .src0_data(b0_data), .src0_valid(b0_valid), .src0_ready(b0_ready),
        .src1_data(b1_data), .src1_valid(b1_valid), .src1_ready(b1_ready),
        .rd_done(b_rd_done), .buf_wr_data(b_wr_data), .buf_wr_addr(b_wr_addr), .buf_wr_en(b_wr_en),
        .buf_switch(b_sw), .frame_ready(b_fr), .wait_rd(b_wt), .stall_cycles(b_stall)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic acc1(input logic [31:0] d0, input logic [31:0] d1, input logic v1, input logic g1, input logic [6:0] addr);
        s0_data = d0;
        s1_data = d1;
        s0_valid = 1;
        s1_valid = v1;
        #1;
        check("rdy0", 32'(s0_ready), 32'(!g1));
        check("rdy1", 32'(s1_ready), 32'(g1));
        tick;
        check("wr_en", 32'(wr_en), 1);
        check("wr_addr", 32'(wr_addr), 32'(addr));
        check("wr_data", wr_data, g1 ? d1 : d0);
    endtask
    task automatic acc2(input logic [31:0] d, input logic [6:0] addr);
        b0_data = d;
        b0_valid = 1;
        #1;
        check("b_rdy", 32'(b0_ready), 1);
        tick;
        check("b_wr_en", 32'(b_wr_en), 1);
        check("b_wr_addr", 32'(b_wr_addr), 32'(addr));
        check("b_wr_data", b_wr_data, d);
    endtask
    initial begin
        tick;
        tick;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_addr", 32'(wr_addr), 0);
        check("rst_data", wr_data, 0);
        check("rst_sw", 32'(sw), 0);
        check("rst_wait", 32'(wt), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_rdy_idle", 32'(s0_ready), 0);
        s0_valid = 1;
        #1;
        check("rst_rdy_valid", 32'(s0_ready), 1);
        s0_valid = 0;
        rst = 0;
        b_rst = 0;
        tick;
        // 2-word frames: free reader, rd_done in DRAIN, then a blocked frame
        acc2(32'h20, 0);
        acc2(32'h21, 1);
        #1;
        check("b_sw_free", 32'(b_sw), 1);
        check("b_rdy_drain", 32'(b0_ready), 0);
        tick;
        check("b_sw_off", 32'(b_sw), 0);
        check("b_wr_idle", 32'(b_wr_en), 0);
        acc2(32'h22, 0);
        acc2(32'h23, 1);
        b_rd_done = 1;
        #1;
        check("b_sw_drain_rd", 32'(b_sw), 1);
        tick;
        b_rd_done = 0;
        acc2(32'h24, 0);
        acc2(32'h25, 1);
        #1;
        check("b_sw_blocked", 32'(b_sw), 0);
        tick;
        check("b_wait", 32'(b_wt), 1);
        check("b_rdy_wait", 32'(b0_ready), 0);
        b_rd_done = 1;
        #1;
        check("b_sw_wait", 32'(b_sw), 1);
        tick;
        b_rd_done = 0;
        #1;
        check("b_wait_off", 32'(b_wt), 0);
        check("b_rdy_back", 32'(b0_ready), 1);
        b0_valid = 0;
        // frame 1: source 0 only, reader free
        for (int i = 0; i < 128; i++) acc1(32'(i), 32'h0, 0, 0, 7'(i));
        #1;
        check("f1_sw", 32'(sw), 1);
        check("f1_fr", 32'(fr), 1);
        check("f1_rdy_drain", 32'(s0_ready), 0);
        check("f1_last_addr", 32'(wr_addr), 127);
        tick;
        check("f1_sw_off", 32'(sw), 0);
        check("f1_wr_idle", 32'(wr_en), 0);
        // frame 2: both valid; source 0 served last, so source 1 leads
        for (int i = 0; i < 128; i++) acc1(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1, (i % 2) == 0, 7'(i));
        #1;
        check("f2_sw_drain", 32'(sw), 0);
        check("f2_rdy0_drain", 32'(s0_ready), 0);
        check("f2_rdy1_drain", 32'(s1_ready), 0);
        tick;
        for (int c = 1; c <= 10; c++) begin
            rd_done = c == 10;
            #1;
            check("f2_wait", 32'(wt), 1);
            check("f2_rdy_wait", 32'(s0_ready | s1_ready), 0);
            check("f2_sw_wait", 32'(sw), 32'(c == 10));
            tick;
        end
        rd_done = 0;
        #1;
        check("f2_wait_off", 32'(wt), 0);
        check("f2_rdy1_back", 32'(s1_ready), 1);
        check("f2_rdy0_back", 32'(s0_ready), 0);
`ifdef PPCTRL_STALL_CNT_EN
        check("f2_stall", 32'(stall), 10);
`else
        check("f2_stall", 32'(stall), 0);
`endif
        // reset after 50 words abandons the frame
        for (int i = 0; i < 50; i++) acc1(32'h100 + 32'(i), 32'h0, 0, 0, 7'(i));
        rst = 1;
        s0_valid = 0;
        tick;
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_addr", 32'(wr_addr), 0);
        check("mid_rst_data", wr_data, 0);
        check("mid_rst_sw", 32'(sw), 0);
        check("mid_rst_stall", 32'(stall), 0);
        rst = 0;
        tick;
        check("post_rst_sw", 32'(sw), 0);
        for (int i = 0; i < 8; i++) acc1(32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i), 1, (i % 2) == 1, 7'(i));
        s0_valid = 0;
        s1_valid = 0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pingpong_wr_ctrl.md
# pingpong_wr_ctrl

Write-side sequencer for the 32-bit-write ping-pong frame buffer. It arbitrates 32-bit words from two sources, generates the word-write address and write enable, and swaps buffers once a frame is full. The swap only happens when the reader has released its half. It sits between the ADAT channel packers and the ping-pong buffer; the byte-wide reader side signals completion back through `rd_done`.

## Interface
Parameters:
- `WORDS_PER_FRAME`, default 128: words per buffer half; legal 2..128.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src0_data`  in  32  word from source 0.
- `src0_valid`  in  1  source 0 has a word.
- `src0_ready`  out  1  source 0 word accepted this cycle when valid is also high.
- `src1_data`, `src1_valid`, `src1_ready`  same as source 0, for source 1.
- `rd_done`  in  1  one-cycle pulse: reader finished with its buffer half.
- `buf_wr_data`  out  32  word to the buffer; registered.
- `buf_wr_addr`  out  7  word address; registered.
- `buf_wr_en`  out  1  write strobe; registered.
- `buf_switch`  out  1  one-cycle pulse: flip the ping-pong halves.
- `frame_ready`  out  1  one-cycle pulse, same cycle as `buf_switch`.
- `wait_rd`  out  1  high while a full frame is blocked waiting on the reader.
- `stall_cycles`  out  16  WAIT_RD cycle counter (see Configuration).

## Operation
- States:
  - FILL: accept words.
  - DRAIN: one cycle after the last write is issued.
  - WAIT_RD: frame full, reader busy.
- Arbitration (FILL only):
  - Only one source is granted per cycle.
  - If one source is valid, it is granted.
  - If both are valid, the source not served by the previous accepted word is granted. `last_served` resets to 1, so source 0 wins first.
  - `srcN_ready` = (state==FILL) & granted==N. The ready signals are combinational from valid and state.
  - Accept = valid & ready.
- Word counter `wcnt`, 7 bits, reset 0:
  - On accept: `buf_wr_data` <= the source data, `buf_wr_addr` <= `wcnt`, `buf_wr_en` <= 1, and `wcnt` increments.
  - `buf_wr_en` is 0 in every cycle with no accept.
- Frame end: the accept with `wcnt`==WORDS_PER_FRAME-1 moves the state to DRAIN and clears `wcnt` to 0.
- `reader_free` flag:
  - Reset value is 1.
  - Cleared in any cycle where `buf_switch`=1.
  - Otherwise set by `rd_done`.
  - `rd_done` while already free has no effect.
- DRAIN:
  - If `reader_free` or `rd_done`: assert `buf_switch` and `frame_ready`, then go to FILL.
  - Otherwise go to WAIT_RD.
- WAIT_RD:
  - `wait_rd`=1.
  - On `rd_done`: assert `buf_switch` and `frame_ready`, then go to FILL.
- `rd_done` in the same cycle as `buf_switch`: the clear wins. That `rd_done` is consumed by this swap.
- Reset mid-frame:
  - State returns to FILL, `wcnt`=0, `reader_free`=1.
  - The partial frame is abandoned and no `buf_switch` is issued.
  - `last_served` returns to 1.
- Reset values: all registered outputs are 0. `srcN_ready` follows its equation, so it is high only if that source is valid.

## Timing
- Accept in cycle N gives `buf_wr_en`/`buf_wr_addr`/`buf_wr_data` in cycle N+1.
- Last accept in cycle N:
  - DRAIN in N+1 while the last write is on the bus.
  - Earliest `buf_switch` in N+1. The buffer flips at the end of N+1, so the last write still lands in the old half.
  - First word of the next frame is accepted no earlier than N+2, written in N+3.
- Blocked frame: `buf_switch` rises in the same cycle as `rd_done`. Ready reasserts the next cycle.
- Peak throughput: one word per cycle, plus one dead (DRAIN) cycle per frame.

## Configuration
- `PPCTRL_STALL_CNT_EN` defined:
  - `stall_cycles` increments once per cycle spent in WAIT_RD.
  - It saturates at 0xFFFF and clears only on `rst`.
- Not defined: `stall_cycles` is constant 0 and no counter logic exists.

## Test plan
- Only src0 valid, 128 words 0x00000000..0x0000007F, reader free:
  - Writes go to addr 0..127 with byte-order data unchanged.
  - `buf_switch` fires one cycle after the addr-127 write issues; ready is low that cycle.
- Both sources always valid: grants alternate 0,1,0,1 starting with source 0, and addresses are contiguous.
- Second frame completes with no `rd_done`:
  - WAIT_RD is entered and `wait_rd`=1 with ready low.
  - `rd_done` after 10 cycles gives `buf_switch` that same cycle and ready the next cycle.
  - With the macro defined, `stall_cycles`=10.
- `rd_done` in the DRAIN cycle with `reader_free`=0: swap happens in DRAIN and `reader_free` stays 0.
- `rst` asserted after 50 accepted words:
  - Outputs go to 0 and no `buf_switch` is issued.
  - The next accepted word is written at addr 0, from source 0 if both are valid.
- `WORDS_PER_FRAME`=2: swaps occur every 2 words and `wcnt` never exceeds 1.
